// File: rtl/word_unpack_pkg.sv
// word_unpack_pkg -- shared definitions for the 16-bit to byte-stream unpacker.
//
// Contents:
//   BYTE_W, WORD_W : default byte and word widths (a word is two bytes)
//   state_t        : unpacker FSM states, 2-bit encoding
//                    IDLE - waiting for a word
//                    HI   - presenting the high byte
//                    LO   - presenting the low byte (final byte of the word)
package word_unpack_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

endpackage : word_unpack_pkg

// File: rtl/word_unpacker.sv
// word_unpacker -- serialises WORD_W-bit words into BYTE_W-bit bytes,
// high byte first, then low byte. One byte per clock when out_ready is held.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_word    : word to serialise, captured on in_valid && in_ready
//   in_valid   : producer offers in_word
//   in_ready   : unpacker will take in_word this cycle
//   out_byte   : current byte (driven from registered state only)
//   out_valid  : out_byte is valid
//   out_ready  : consumer takes out_byte this cycle
//   out_last   : out_byte is the final byte of its word
//   word_count : number of fully emitted words, wraps modulo 2^CNT_W
//   dbg_state  : current FSM state (IDLE/HI/LO encoding from word_unpack_pkg)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the offering side holds its data stable until that edge and
// ready never depends on the data itself.
//
// Build option: define WORD_UNPACKER_SKIP_ZERO_LO_EN to drop a zero low
// byte, so the high byte is then the last byte of the word.
module word_unpacker #(
    parameter int WORD_W = 16,
    parameter int BYTE_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [CNT_W-1:0]  word_count,
    output logic [1:0]        dbg_state
);
    import word_unpack_pkg::*;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_HI   = HI;
    localparam logic [1:0] ST_LO   = LO;

    logic [1:0]        state;
    logic [WORD_W-1:0] word_reg;
    logic [CNT_W-1:0]  cnt;
    logic              hi_final;
    logic              word_done;
    logic              accept;

    // hi_final: the high byte is also the last byte of this word.
`ifdef WORD_UNPACKER_SKIP_ZERO_LO_EN
    assign hi_final = (word_reg[BYTE_W-1:0] == '0);
`else
    assign hi_final = 1'b0;
`endif

    // The final byte of the current word is being handed over this cycle.
    assign word_done = out_ready &&
                       ((state == ST_LO) || ((state == ST_HI) && hi_final));

    // Accepting during the final-byte handshake gives back-to-back words.
    // Gating with rst_n keeps in_ready low for the whole reset interval.
    assign in_ready = rst_n && ((state == ST_IDLE) || word_done);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid = 1'b0;
        out_byte  = '0;
        out_last  = 1'b0;
        case (state)
            ST_HI: begin
                out_valid = 1'b1;
                out_byte  = word_reg[WORD_W-1:BYTE_W];
                out_last  = hi_final;
            end
            ST_LO: begin
                out_valid = 1'b1;
                out_byte  = word_reg[BYTE_W-1:0];
                out_last  = 1'b1;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            word_reg <= '0;
            cnt      <= '0;
        end else begin
            if (accept) begin
                word_reg <= in_word;
                state    <= ST_HI;
            end else if (word_done) begin
                state <= ST_IDLE;
            end else if ((state == ST_HI) && out_ready) begin
                state <= ST_LO;
            end else if ((state != ST_HI) && (state != ST_LO) && (state != ST_IDLE)) begin
                // Unused encoding: recover to IDLE rather than lock up.
                state <= ST_IDLE;
            end

            if (word_done) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign word_count = cnt;
    assign dbg_state  = state;

endmodule : word_unpacker
